// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multicycle core (16-bit instruction encoding).
// Contains the gated instruction register, the control FSM, the register file,
// the A/B/C operand registers, the B shifter, the ALU and the N/V/Z status flags.
//
// Parameters:
//   DATA_W  datapath/register width (>= 8)
//   NREG    implemented registers (2..8); other indices read 0 and drop writes
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   s         start, sampled only while waiting
//   load      instruction register load enable (honoured only while waiting)
//   in        16-bit instruction word
//   out       C register contents
//   N, V, Z   status flags, written only by CMP
//   w         high exactly while the FSM is in WAIT
//
// Optional feature (macro CPU_CORE_DBG_EN):
//   dbg_sel   register index to observe
//   dbg_data  combinational R[dbg_sel], 0 for an unimplemented index
module cpu_core_param #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w
`ifdef CPU_CORE_DBG_EN
    ,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
`endif
);

    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GETA, S_GETB, S_EXEC, S_WREG, S_WIMM
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] alu;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_t;

    instr_t                       ir;
    state_t                       state, state_nx;
    logic [NREG-1:0][DATA_W-1:0]  regs;
    logic [DATA_W-1:0]            a_q, b_q, c_q;
    logic                         n_q, v_q, z_q;
    logic [DATA_W-1:0]            sximm8, b_sh, alu_a, alu_res;
    logic                         is_movi, is_movr, is_alu, is_mvn, is_cmp;

    // Index decode by search so an index at or above NREG simply matches nothing.
    function automatic logic [DATA_W-1:0] rd_reg(input logic [NREG-1:0][DATA_W-1:0] rf,
                                                 input logic [2:0] idx);
        rd_reg = '0;
        for (int i = 0; i < NREG; i++)
            if (idx == 3'(i)) rd_reg = rf[i];
    endfunction

    // ---------------- decode ----------------
    assign is_movi = (ir.op == 3'b110) && (ir.alu == 2'b10);
    assign is_movr = (ir.op == 3'b110) && (ir.alu == 2'b00);
    assign is_alu  = (ir.op == 3'b101);
    assign is_mvn  = is_alu && (ir.alu == 2'b11);
    assign is_cmp  = is_alu && (ir.alu == 2'b01);

    // imm8 occupies the Rd/sh/Rm fields.
    always_comb begin
        sximm8      = {DATA_W{ir.rd[2]}};
        sximm8[7:0] = {ir.rd, ir.sh, ir.rm};
    end

    // ---------------- shifter + ALU ----------------
    always_comb begin
        b_sh = b_q;
        case (ir.sh)
            2'b01:   b_sh = {b_q[MSB-1:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[MSB:1]};
            2'b11:   b_sh = {b_q[MSB], b_q[MSB:1]};
            default: b_sh = b_q;
        endcase
    end

    // MOV reg goes through the adder with a zero A operand; A is never loaded for it.
    assign alu_a = is_movr ? '0 : a_q;

    always_comb begin
        alu_res = '0;
        case (ir.alu)
            2'b00:   alu_res = alu_a + b_sh;
            2'b01:   alu_res = alu_a - b_sh;
            2'b10:   alu_res = alu_a & b_sh;
            default: alu_res = ~b_sh;
        endcase
    end

    // ---------------- instruction register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        ir <= '0;
        else if (load && state == S_WAIT) ir <= instr_t'(in);
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_WAIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT:   if (s) state_nx = S_DECODE;
            S_DECODE: begin
                if (is_movi)                state_nx = S_WIMM;
                else if (is_movr || is_mvn) state_nx = S_GETB;
                else if (is_alu)            state_nx = S_GETA;
                else                        state_nx = S_WAIT;
            end
            S_GETA:   state_nx = S_GETB;
            S_GETB:   state_nx = S_EXEC;
            S_EXEC:   state_nx = is_cmp ? S_WAIT : S_WREG;
            S_WREG:   state_nx = S_WAIT;
            S_WIMM:   state_nx = S_WAIT;
            default:  state_nx = S_WAIT;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '0;
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= '0;
            n_q  <= 1'b0;
            v_q  <= 1'b0;
            z_q  <= 1'b0;
        end else begin
            case (state)
                S_GETA: a_q <= rd_reg(regs, ir.rn);
                S_GETB: b_q <= rd_reg(regs, ir.rm);
                S_EXEC: begin
                    if (is_cmp) begin
                        n_q <= alu_res[MSB];
                        z_q <= (alu_res == '0);
                        // subtraction overflows when operand signs differ and
                        // the result sign differs from the minuend
                        v_q <= (a_q[MSB] != b_sh[MSB]) && (alu_res[MSB] != a_q[MSB]);
                    end else begin
                        c_q <= alu_res;
                    end
                end
                S_WREG: for (int i = 0; i < NREG; i++)
                            if (ir.rd == 3'(i)) regs[i] <= c_q;
                S_WIMM: for (int i = 0; i < NREG; i++)
                            if (ir.rn == 3'(i)) regs[i] <= sximm8;
                default: ;
            endcase
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
    assign w   = (state == S_WAIT);

`ifdef CPU_CORE_DBG_EN
    assign dbg_data = rd_reg(regs, dbg_sel);
`endif

endmodule

// File: tb/tb_cpu_core_param.sv
module tb_cpu_core_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] in = '0;
    logic [2:0]  s_v = '0;
    logic [2:0]  wv;
    logic [15:0] outv [3];
    logic [2:0]  nvzv [3];

    logic [15:0] out0, out2;
    logic [7:0]  out1;
    logic        n0, v0, z0, n1, v1, z1, n2, v2, z2, w0, w1, w2;
`ifdef CPU_CORE_DBG_EN
    logic [2:0]  dbg_sel = '0;
    logic [15:0] dbg0, dbg2;
    logic [7:0]  dbg1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] out;
        logic [2:0]  nvz;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    // dut0: 16-bit, 8 regs; dut1: 8-bit, 8 regs; dut2: 16-bit, 4 regs
    cpu_core_param #(.DATA_W(16), .NREG(8)) dut0 (
        .clk(clk), .reset(reset), .s(s_v[0]), .load(load), .in(in),
        .out(out0), .N(n0), .V(v0), .Z(z0), .w(w0)
`ifdef CPU_CORE_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_data(dbg0)
`endif
    );
    cpu_core_param #(.DATA_W(8), .NREG(8)) dut1 (
        .clk(clk), .reset(reset), .s(s_v[1]), .load(load), .in(in),
        .out(out1), .N(n1), .V(v1), .Z(z1), .w(w1)
`ifdef CPU_CORE_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_data(dbg1)
`endif
    );
    cpu_core_param #(.DATA_W(16), .NREG(4)) dut2 (
        .clk(clk), .reset(reset), .s(s_v[2]), .load(load), .in(in),
        .out(out2), .N(n2), .V(v2), .Z(z2), .w(w2)
`ifdef CPU_CORE_DBG_EN
        , .dbg_sel(dbg_sel), .dbg_data(dbg2)
`endif
    );

    assign wv      = {w2, w1, w0};
    assign outv[0] = out0;
    assign outv[1] = {8'h00, out1};
    assign outv[2] = out2;
    assign nvzv[0] = {n0, v0, z0};
    assign nvzv[1] = {n1, v1, z1};
    assign nvzv[2] = {n2, v2, z2};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor: pops an expectation on every return to WAIT ----------------
    logic [2:0] wd = 3'b111;
    int         lowc [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                lowc[k] = 0;
            end else if (!wv[k]) begin
                lowc[k]++;
            end else if (!wd[k]) begin
                exp_t e;
                bit   have = 1'b0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                if (!have) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dut%0d_unexpected: completion with no expectation queued", k);
                end else begin
                    chk($sformatf("dut%0d_lat", k), 16'(lowc[k] + 1), 16'(e.lat));
                    chk($sformatf("dut%0d_out", k), outv[k], e.out);
                    chk($sformatf("dut%0d_nvz", k), 16'(nvzv[k]), 16'(e.nvz));
                end
                lowc[k] = 0;
            end
            wd[k] = wv[k];
        end
    end

    // ---------------- stimulus ----------------
    // Optionally load ins, pulse s, optionally try a load while busy, then wait for WAIT.
    task automatic issue(input int k, input logic [15:0] ins, input bit do_load,
                         input bit ld_busy, input logic [15:0] eo, input logic [2:0] en,
                         input int el);
        exp_t e;
        int   n;
        e.out = eo; e.nvz = en; e.lat = el;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        @(negedge clk);
        if (do_load) begin in = ins; load = 1'b1; end
        @(negedge clk);
        load   = 1'b0;
        s_v[k] = 1'b1;
        @(negedge clk);
        s_v = '0;
        if (ld_busy) begin
            @(negedge clk);
            in = 16'hD3FF; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
        end
        n = 0;
        while (!wv[k] && n < 20) begin @(negedge clk); n++; end
        if (!wv[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d_timeout: w stayed %b, required 1", k, wv[k]);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_w", k), 16'(wv[k]), 16'h1);
            chk($sformatf("rst%0d_out", k), outv[k], 16'h0);
            chk($sformatf("rst%0d_nvz", k), 16'(nvzv[k]), 16'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        // ---- dut0: DATA_W=16, NREG=8 ----
        issue(0, 16'hD007, 1, 0, 16'h0000, 3'b000, 3);  // MOV R0,#7
        issue(0, 16'hD1FE, 1, 0, 16'h0000, 3'b000, 3);  // MOV R1,#-2
        issue(0, 16'hA148, 1, 0, 16'h000C, 3'b000, 6);  // ADD R2,R1,R0,LSL#1
        issue(0, 16'hA800, 1, 0, 16'h000C, 3'b001, 5);  // CMP R0,R0
        issue(0, 16'hC042, 1, 0, 16'h000C, 3'b001, 5);  // MOV R2,R2 readback
        issue(0, 16'hB871, 1, 0, 16'h8000, 3'b001, 5);  // MVN R3,R1,LSR#1
        issue(0, 16'hB198, 1, 0, 16'h0002, 3'b001, 6);  // AND R4,R1,R0,ASR#1
        issue(0, 16'hA900, 1, 0, 16'h0002, 3'b100, 5);  // CMP R1,R0 -> FFF7
        issue(0, 16'hE000, 1, 0, 16'h0002, 3'b100, 2);  // undefined op: no effect
        issue(0, 16'hA148, 1, 1, 16'h000C, 3'b100, 6);  // ADD with load attempted in GETA
        issue(0, 16'hA148, 0, 0, 16'h000C, 3'b100, 6);  // re-start: still the ADD
        issue(0, 16'hC063, 1, 0, 16'h8000, 3'b100, 5);  // MOV R3,R3: untouched by D3FF

        // reset during GETA of an ADD
        @(negedge clk); in = 16'hA148; load = 1'b1;
        @(negedge clk); load = 1'b0; s_v[0] = 1'b1;
        @(negedge clk); s_v = '0;
        @(negedge clk); reset = 1'b0;
        #1;
        chk("abort_w", 16'(w0), 16'h1);
        chk("abort_out", out0, 16'h0);
        chk("abort_nvz", 16'({n0, v0, z0}), 16'h0);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        for (int x = 0; x < 8; x++) begin
            logic [15:0] v;
            v = 16'hC000 | 16'(x << 5) | 16'(x);  // MOV Rx,Rx
            issue(0, v, 1, 0, 16'h0000, 3'b000, 5);
        end

        // ---- dut1: DATA_W=8 ----
        issue(1, 16'hD07F, 1, 0, 16'h0000, 3'b000, 3);  // R0=7F
        issue(1, 16'hD180, 1, 0, 16'h0000, 3'b000, 3);  // R1=80
        issue(1, 16'hA801, 1, 0, 16'h0000, 3'b110, 5);  // CMP R0,R1: 7F-80 overflows
        issue(1, 16'hA041, 1, 0, 16'h00FF, 3'b110, 6);  // ADD R2,R0,R1
        issue(1, 16'hC071, 1, 0, 16'h0040, 3'b110, 5);  // MOV R3,R1,LSR#1
        issue(1, 16'hC079, 1, 0, 16'h00C0, 3'b110, 5);  // MOV R3,R1,ASR#1

        // ---- dut2: NREG=4 ----
        issue(2, 16'hD109, 1, 0, 16'h0000, 3'b000, 3);  // MOV R1,#9
        issue(2, 16'hC001, 1, 0, 16'h0009, 3'b000, 5);  // MOV R0,R1
        issue(2, 16'hD509, 1, 0, 16'h0009, 3'b000, 3);  // MOV R5,#9 dropped
        issue(2, 16'hC005, 1, 0, 16'h0000, 3'b000, 5);  // MOV R0,R5 reads 0
`ifdef CPU_CORE_DBG_EN
        dbg_sel = 3'd5;
        #1 chk("dbg_r5", dbg2, 16'h0000);
        dbg_sel = 3'd1;
        #1 chk("dbg_r1", dbg2, 16'h0009);
`endif

        repeat (4) @(negedge clk);
        chk("q0_empty", 16'(q0.size()), 16'h0);
        chk("q1_empty", 16'(q1.size()), 16'h0);
        chk("q2_empty", 16'(q2.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
